// File: rtl/bypass_scoreboard_pkg.sv
// Shared widths and types for the operand-bypass stage and its per-source mux.
package pkg_opengpu;

    localparam int unsigned WARPS_PER_CORE = 4;
    localparam int unsigned WARP_ID_WIDTH  = 2;
    localparam int unsigned WARP_SIZE      = 4;
    localparam int unsigned DATA_WIDTH     = 8;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned NUM_TAPS_DEF   = 3;
    localparam int unsigned FWD_SRC_WIDTH  = $clog2(NUM_TAPS_DEF + 1);

    typedef logic [FWD_SRC_WIDTH-1:0] fwd_src_t;
    typedef logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] warp_data_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/bypass_scoreboard_src_mux.sv
// One source operand: tap match with youngest-first priority, data select and hazard detection.
module bypass_src_mux
    import pkg_opengpu::*;
#(
    parameter int unsigned NUM_TAPS = 3,
    parameter int unsigned SRC_W    = $clog2(NUM_TAPS + 1)
) (
    input  logic [WARP_ID_WIDTH-1:0]                warp_id,
    input  logic [REG_ADDR_WIDTH-1:0]               rs,
    input  logic                                    rs_used,
    input  logic                                    sb_pending,
    input  warp_data_t                              rf_data,
    input  logic [NUM_TAPS-1:0]                     tap_valid,
    input  logic [NUM_TAPS*WARP_ID_WIDTH-1:0]       tap_warp_id,
    input  logic [NUM_TAPS*REG_ADDR_WIDTH-1:0]      tap_rd,
    input  logic [NUM_TAPS-1:0]                     tap_reg_write,
    input  logic [NUM_TAPS-1:0]                     tap_data_ok,
    input  logic [NUM_TAPS*$bits(warp_data_t)-1:0]  tap_data,
    output warp_data_t                              data,
    output logic [SRC_W-1:0]                        src,
    output logic                                    hazard
);

    localparam int unsigned WD = $bits(warp_data_t);

    logic                live;
    logic                hit;
    logic [NUM_TAPS-1:0] match;

    assign live = rs_used && (rs != '0);

    always_comb begin
        match = '0;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            match[k] = live && tap_valid[k] && tap_reg_write[k]
                    && (tap_warp_id[k*WARP_ID_WIDTH +: WARP_ID_WIDTH] == warp_id)
                    && (tap_rd[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == rs);
        end
    end

    // Only the youngest matching tap counts; an older tap never overrides a stalled younger one.
    always_comb begin
        hit    = 1'b0;
        data   = rf_data;
        src    = '0;
        hazard = live && sb_pending;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            if (match[k] && !hit) begin
                hit    = 1'b1;
                hazard = !tap_data_ok[k];
                if (tap_data_ok[k]) begin
                    data = tap_data[k*WD +: WD];
                    src  = SRC_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/bypass_scoreboard.sv
// Registered operand-bypass stage with per-warp long-latency scoreboard interlock.
// Define BYPASS_SB_PERF_EN to build the saturating stall/forward performance counters.
module bypass_scoreboard
    import pkg_opengpu::*;
#(
    parameter int unsigned NUM_WARPS = WARPS_PER_CORE,
    parameter int unsigned NUM_SRCS  = 3,
    parameter int unsigned NUM_TAPS  = 3,
    parameter int unsigned NUM_REGS  = 2**REG_ADDR_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [WARP_ID_WIDTH-1:0]                   in_warp_id,
    input  logic [NUM_SRCS*REG_ADDR_WIDTH-1:0]         in_rs,
    input  logic [NUM_SRCS-1:0]                        in_rs_used,
    input  logic [REG_ADDR_WIDTH-1:0]                  in_rd,
    input  logic                                       in_reg_write,
    input  logic                                       in_long_lat,
    input  logic [NUM_SRCS*WARP_SIZE*DATA_WIDTH-1:0]   in_rf_data,
    input  logic [NUM_TAPS-1:0]                        tap_valid,
    input  logic [NUM_TAPS*WARP_ID_WIDTH-1:0]          tap_warp_id,
    input  logic [NUM_TAPS*REG_ADDR_WIDTH-1:0]         tap_rd,
    input  logic [NUM_TAPS-1:0]                        tap_reg_write,
    input  logic [NUM_TAPS-1:0]                        tap_data_ok,
    input  logic [NUM_TAPS*WARP_SIZE*DATA_WIDTH-1:0]   tap_data,
    input  logic                                       wb_commit,
    input  logic [WARP_ID_WIDTH-1:0]                   wb_warp_id,
    input  logic [REG_ADDR_WIDTH-1:0]                  wb_rd,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [WARP_ID_WIDTH-1:0]                   out_warp_id,
    output logic [NUM_SRCS*WARP_SIZE*DATA_WIDTH-1:0]   out_data,
    output logic [NUM_SRCS*$clog2(NUM_TAPS+1)-1:0]     out_src,
    output logic [31:0]                                perf_stall_cnt,
    output logic [31:0]                                perf_fwd_cnt
);

    localparam int unsigned SRC_W = $clog2(NUM_TAPS + 1);
    localparam int unsigned WD    = WARP_SIZE * DATA_WIDTH;
    localparam int unsigned RW    = REG_ADDR_WIDTH;

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] sb;
    logic [NUM_SRCS*WD-1:0]             mux_data;
    logic [NUM_SRCS*SRC_W-1:0]          mux_src;
    logic [NUM_SRCS-1:0]                src_hazard;
    logic                               any_hazard;
    logic                               accept;
    logic                               sb_set;

    for (genvar s = 0; s < NUM_SRCS; s++) begin : g_src
        bypass_src_mux #(
            .NUM_TAPS (NUM_TAPS),
            .SRC_W    (SRC_W)
        ) u_mux (
            .warp_id       (in_warp_id),
            .rs            (in_rs[s*RW +: RW]),
            .rs_used       (in_rs_used[s]),
            .sb_pending    (sb[in_warp_id][in_rs[s*RW +: RW]]),
            .rf_data       (in_rf_data[s*WD +: WD]),
            .tap_valid     (tap_valid),
            .tap_warp_id   (tap_warp_id),
            .tap_rd        (tap_rd),
            .tap_reg_write (tap_reg_write),
            .tap_data_ok   (tap_data_ok),
            .tap_data      (tap_data),
            .data          (mux_data[s*WD +: WD]),
            .src           (mux_src[s*SRC_W +: SRC_W]),
            .hazard        (src_hazard[s])
        );
    end

    assign any_hazard = |src_hazard;
    assign in_ready   = !any_hazard && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign sb_set     = accept && in_reg_write && in_long_lat && (in_rd != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_warp_id <= '0;
            out_data    <= '0;
            out_src     <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_warp_id <= in_warp_id;
            out_data    <= mux_data;
            out_src     <= mux_src;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Set is written after clear so a new producer wins over a same-cycle commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            if (wb_commit) sb[wb_warp_id][wb_rd] <= 1'b0;
            if (sb_set)    sb[in_warp_id][in_rd] <= 1'b1;
        end
    end

`ifdef BYPASS_SB_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
    logic [31:0] fwd_inc;

    always_comb begin
        fwd_inc = '0;
        for (int unsigned s = 0; s < NUM_SRCS; s++) begin
            if (mux_src[s*SRC_W +: SRC_W] != '0) fwd_inc = fwd_inc + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (in_valid && any_hazard) stall_cnt <= sat_add32(stall_cnt, 32'd1);
            if (accept)                 fwd_cnt   <= sat_add32(fwd_cnt, fwd_inc);
        end
    end

    assign perf_stall_cnt = stall_cnt;
    assign perf_fwd_cnt   = fwd_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Randomized bench for bypass_scoreboard against a behavioural forwarding/scoreboard model.
// Counter checks follow BYPASS_SB_PERF_EN when it is defined for the build.
module tb_bypass_scoreboard;
    import pkg_opengpu::*;

    localparam int unsigned NW = WARPS_PER_CORE;
    localparam int unsigned NS = 3;
    localparam int unsigned NT = 3;
    localparam int unsigned RW = REG_ADDR_WIDTH;
    localparam int unsigned WW = WARP_ID_WIDTH;
    localparam int unsigned WD = WARP_SIZE * DATA_WIDTH;
    localparam int unsigned SW = FWD_SRC_WIDTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WW-1:0]     in_warp_id;
    logic [NS*RW-1:0]  in_rs;
    logic [NS-1:0]     in_rs_used;
    logic [RW-1:0]     in_rd;
    logic              in_reg_write;
    logic              in_long_lat;
    logic [NS*WD-1:0]  in_rf_data;
    logic [NT-1:0]     tap_valid;
    logic [NT*WW-1:0]  tap_warp_id;
    logic [NT*RW-1:0]  tap_rd;
    logic [NT-1:0]     tap_reg_write;
    logic [NT-1:0]     tap_data_ok;
    logic [NT*WD-1:0]  tap_data;
    logic              wb_commit;
    logic [WW-1:0]     wb_warp_id;
    logic [RW-1:0]     wb_rd;
    logic              out_valid;
    logic              out_ready;
    logic [WW-1:0]     out_warp_id;
    logic [NS*WD-1:0]  out_data;
    logic [NS*SW-1:0]  out_src;
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_fwd_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference state
    bit               m_pend [NW][2**RW];
    logic             m_valid;
    logic [WW-1:0]    m_warp;
    logic [NS*WD-1:0] m_data;
    logic [NS*SW-1:0] m_src;
    logic [31:0]      m_stall;
    logic [31:0]      m_fwd;
    logic             e_ready;
    logic             e_haz;
    logic [NS*WD-1:0] e_data;
    logic [NS*SW-1:0] e_src;
    int unsigned      e_nfwd;

    always #5 clk = ~clk;

    bypass_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_warp_id     (in_warp_id),
        .in_rs          (in_rs),
        .in_rs_used     (in_rs_used),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .in_long_lat    (in_long_lat),
        .in_rf_data     (in_rf_data),
        .tap_valid      (tap_valid),
        .tap_warp_id    (tap_warp_id),
        .tap_rd         (tap_rd),
        .tap_reg_write  (tap_reg_write),
        .tap_data_ok    (tap_data_ok),
        .tap_data       (tap_data),
        .wb_commit      (wb_commit),
        .wb_warp_id     (wb_warp_id),
        .wb_rd          (wb_rd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_warp_id    (out_warp_id),
        .out_data       (out_data),
        .out_src        (out_src),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
    );

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[w, r]) m_pend[w][r] = 1'b0;
        m_valid = 1'b0;
        m_warp  = '0;
        m_data  = '0;
        m_src   = '0;
        m_stall = '0;
        m_fwd   = '0;
    endtask

    // Operand selection straight from the forwarding rules: first (youngest) matching tap wins.
    task automatic model_eval();
        e_haz  = 1'b0;
        e_nfwd = 0;
        e_data = in_rf_data;
        e_src  = '0;
        for (int s = 0; s < NS; s++) begin
            logic [RW-1:0] rs;
            bit live;
            int win;
            rs   = in_rs[s*RW +: RW];
            live = in_rs_used[s] && (rs != 0);
            win  = -1;
            for (int k = 0; k < NT; k++) begin
                if (win < 0 && live && tap_valid[k] && tap_reg_write[k] &&
                    tap_warp_id[k*WW +: WW] == in_warp_id && tap_rd[k*RW +: RW] == rs)
                    win = k;
            end
            if (win >= 0) begin
                if (tap_data_ok[win]) begin
                    e_data[s*WD +: WD] = tap_data[win*WD +: WD];
                    e_src[s*SW +: SW]  = SW'(win + 1);
                    e_nfwd++;
                end else begin
                    e_haz = 1'b1;
                end
            end else if (live && m_pend[in_warp_id][rs]) begin
                e_haz = 1'b1;
            end
        end
        e_ready = !e_haz && (!m_valid || out_ready);
    endtask

    // Called at the falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        bit acc;
        logic [32:0] fsum;
        #1;
        model_eval();
        check_eq("in_ready", in_ready, e_ready);
        acc = in_valid && e_ready;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (in_valid && e_haz && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (acc) begin
                m_valid = 1'b1;
                m_warp  = in_warp_id;
                m_data  = e_data;
                m_src   = e_src;
                fsum    = {1'b0, m_fwd} + 33'(e_nfwd);
                m_fwd   = fsum[32] ? 32'hFFFF_FFFF : fsum[31:0];
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_commit) m_pend[wb_warp_id][wb_rd] = 1'b0;
            if (acc && in_reg_write && in_long_lat && in_rd != 0) m_pend[in_warp_id][in_rd] = 1'b1;
        end
        check_eq("out_valid", out_valid, m_valid);
        check_eq("out_warp_id", out_warp_id, m_warp);
        check_eq("out_data", out_data, m_data);
        check_eq("out_src", out_src, m_src);
`ifdef BYPASS_SB_PERF_EN
        check_eq("perf_stall", perf_stall_cnt, m_stall);
        check_eq("perf_fwd", perf_fwd_cnt, m_fwd);
`else
        check_eq("perf_stall_off", perf_stall_cnt, 32'd0);
        check_eq("perf_fwd_off", perf_fwd_cnt, 32'd0);
`endif
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        in_valid      = 1'b0;
        in_warp_id    = '0;
        in_rs         = '0;
        in_rs_used    = '0;
        in_rd         = '0;
        in_reg_write  = 1'b0;
        in_long_lat   = 1'b0;
        in_rf_data    = {$urandom, $urandom, $urandom};
        tap_valid     = '0;
        tap_warp_id   = '0;
        tap_rd        = '0;
        tap_reg_write = '0;
        tap_data_ok   = '0;
        tap_data      = {$urandom, $urandom, $urandom};
        wb_commit     = 1'b0;
        wb_warp_id    = '0;
        wb_rd         = '0;
        out_ready     = 1'b1;
    endtask

    task automatic set_tap(input int k, input int w, input int rd, input bit ok, input logic [31:0] d);
        tap_valid[k]          = 1'b1;
        tap_reg_write[k]      = 1'b1;
        tap_warp_id[k*WW +: WW] = WW'(w);
        tap_rd[k*RW +: RW]    = RW'(rd);
        tap_data_ok[k]        = ok;
        tap_data[k*WD +: WD]  = d;
    endtask

    task automatic random_inputs();
        in_valid     = ($urandom_range(0, 4) != 0);
        in_warp_id   = WW'($urandom_range(0, NW - 1));
        for (int s = 0; s < NS; s++) begin
            in_rs[s*RW +: RW] = RW'($urandom_range(0, 7));
            in_rs_used[s]     = ($urandom_range(0, 3) != 0);
        end
        in_rd        = RW'($urandom_range(0, 7));
        in_reg_write = ($urandom_range(0, 9) < 7);
        in_long_lat  = ($urandom_range(0, 9) < 3);
        in_rf_data   = {$urandom, $urandom, $urandom};
        for (int k = 0; k < NT; k++) begin
            tap_valid[k]            = ($urandom_range(0, 9) < 6);
            tap_warp_id[k*WW +: WW] = $urandom_range(0, 1) ? in_warp_id : WW'($urandom_range(0, NW - 1));
            tap_rd[k*RW +: RW]      = RW'($urandom_range(0, 7));
            tap_reg_write[k]        = ($urandom_range(0, 9) < 8);
            tap_data_ok[k]          = ($urandom_range(0, 9) < 7);
        end
        tap_data     = {$urandom, $urandom, $urandom};
        wb_commit    = ($urandom_range(0, 9) < 4);
        wb_warp_id   = WW'($urandom_range(0, NW - 1));
        wb_rd        = RW'($urandom_range(1, 7));
        out_ready    = ($urandom_range(0, 9) < 7);
        rst_n        = ($urandom_range(0, 199) != 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_warp", out_warp_id, '0);
        check_eq("rst_out_data", out_data, '0);
        check_eq("rst_out_src", out_src, '0);
        check_eq("rst_perf_stall", perf_stall_cnt, '0);
        check_eq("rst_perf_fwd", perf_fwd_cnt, '0);
        model_reset();
        rst_n = 1'b1;
        step();

        // Youngest tap forwards with one cycle of latency
        clear_inputs();
        set_tap(0, 2, 5, 1'b1, 32'hA5A5_0001);
        in_valid = 1'b1; in_warp_id = 2; in_rs[0 +: RW] = 5; in_rs_used = 3'b001;
        step();
        check_eq("fwd_tap0_src", out_src[0 +: SW], 1);
        check_eq("fwd_tap0_data", out_data[0 +: WD], 32'hA5A5_0001);

        // Two matching taps: tap0 has priority
        clear_inputs();
        set_tap(0, 1, 7, 1'b1, 32'h1111_0000);
        set_tap(2, 1, 7, 1'b1, 32'h2222_0000);
        in_valid = 1'b1; in_warp_id = 1; in_rs[RW +: RW] = 7; in_rs_used = 3'b010;
        step();
        check_eq("prio_src1", out_src[SW +: SW], 1);
        check_eq("prio_data1", out_data[WD +: WD], 32'h1111_0000);

        // Load sets pending bit; dependent stalls until writeback
        clear_inputs();
        in_valid = 1'b1; in_warp_id = 1; in_rd = 9; in_reg_write = 1'b1; in_long_lat = 1'b1;
        step();
        clear_inputs();
        in_valid = 1'b1; in_warp_id = 1; in_rs[0 +: RW] = 9; in_rs_used = 3'b001;
        #1 check_eq("sb_stall", in_ready, 1'b0);
        step();
        step();
        wb_commit = 1'b1; wb_warp_id = 1; wb_rd = 9;
        step();
        wb_commit = 1'b0;
        #1 check_eq("sb_release", in_ready, 1'b1);
        step();
        check_eq("sb_rf_src", out_src[0 +: SW], 0);
        check_eq("sb_rf_data", out_data[0 +: WD], in_rf_data[0 +: WD]);

        // Same-cycle set and clear of one bit: set wins
        clear_inputs();
        in_valid = 1'b1; in_warp_id = 3; in_rd = 4; in_reg_write = 1'b1; in_long_lat = 1'b1;
        wb_commit = 1'b1; wb_warp_id = 3; wb_rd = 4;
        step();
        clear_inputs();
        in_valid = 1'b1; in_warp_id = 3; in_rs[0 +: RW] = 4; in_rs_used = 3'b001;
        #1 check_eq("set_wins_stall", in_ready, 1'b0);
        step();
        wb_commit = 1'b1; wb_warp_id = 3; wb_rd = 4;
        step();
        wb_commit = 1'b0;
        step();

        // r0 never forwarded or stalled; other-warp taps are ignored
        clear_inputs();
        set_tap(0, 0, 0, 1'b0, 32'hDEAD_0000);
        set_tap(1, 1, 3, 1'b1, 32'hBEEF_0000);
        in_valid = 1'b1; in_warp_id = 0; in_rs[0 +: RW] = 0; in_rs[RW +: RW] = 3; in_rs_used = 3'b011;
        #1 check_eq("r0_no_stall", in_ready, 1'b1);
        step();
        check_eq("r0_src", out_src[0 +: SW], 0);
        check_eq("warp_mismatch_src", out_src[SW +: SW], 0);

        // Backpressure: outputs held and no new accept
        clear_inputs();
        in_valid = 1'b1; in_warp_id = 2; in_rs_used = 3'b000;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_rf_data = {$urandom, $urandom, $urandom};
            #1 check_eq("bp_ready", in_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        step();

        // Stall on a not-ready tap for five cycles
        clear_inputs();
        set_tap(0, 1, 6, 1'b0, 32'h0);
        in_valid = 1'b1; in_warp_id = 1; in_rs[0 +: RW] = 6; in_rs_used = 3'b001;
        for (int i = 0; i < 5; i++) step();
        clear_inputs();
        step();

        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
